// File: rtl/mmp_iddmm_pkg.sv
// Shared definitions for the IDDMM MMP core and its job feeder.
// Holds the default word geometry and the feeder FSM state encoding.
package mmp_iddmm_pkg;
  localparam int MMP_K = 128;
  localparam int MMP_N = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    REQ   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } feeder_state_e;
endpackage

// File: rtl/mmp_iddmm_feeder_if.sv
// Job-in stream, core RAM/task signals and result-out stream of the feeder.
// master = feeder side, slave = upstream/core/downstream environment side.
interface mmp_iddmm_feeder_if import mmp_iddmm_pkg::*; #(
  parameter int K      = MMP_K,
  parameter int ADDR_W = $clog2(MMP_N)
);
  logic              in_valid;
  logic              in_ready;
  logic [K-1:0]      in_x;
  logic [K-1:0]      in_y;
  logic [K-1:0]      in_m;
  logic [K-1:0]      in_m1;
  logic              in_last;
  logic [2:0]        wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_x;
  logic [K-1:0]      wr_y;
  logic [K-1:0]      wr_m;
  logic [K-1:0]      wr_m1;
  logic              task_req;
  logic              task_end;
  logic              task_grant;
  logic [K-1:0]      task_res;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic              out_last;

  modport master (
    input  in_valid, in_x, in_y, in_m, in_m1, in_last,
    output in_ready,
    output wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
    input  task_end, task_grant, task_res,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output in_valid, in_x, in_y, in_m, in_m1, in_last,
    input  in_ready,
    input  wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
    output task_end, task_grant, task_res,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/mmp_feeder_res_buf.sv
// N x K result buffer: one synchronous write port, one asynchronous read port.
// Latency: write visible next cycle, read combinational; no flow control.
module mmp_feeder_res_buf import mmp_iddmm_pkg::*; #(
  parameter int K      = MMP_K,
  parameter int N      = MMP_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [K-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [K-1:0]      rdata
);
  logic [K-1:0] mem [N];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mmp_iddmm_feeder.sv
// Job loader / result drainer for the IDDMM MMP core; one job in flight. Latency: N load + 2 + core + N drain.
// Backpressure: in_valid gaps stall loading, out_ready low holds out_data. Option MMP_FEEDER_PERF_EN adds perf_cycles.
module mmp_iddmm_feeder import mmp_iddmm_pkg::*; #(
  parameter int K      = MMP_K,
  parameter int N      = MMP_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmp_iddmm_feeder_if.master   bus,
  output logic                 busy,
  output logic                 proto_err
`ifdef MMP_FEEDER_PERF_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] FULL     = CW'(N);

  feeder_state_e state, state_nxt;
  logic [CW-1:0] bcnt, gcnt, rcnt;
  logic          end_seen;
  logic          in_acc, grant_ok, grant_done, out_acc;
  logic [K-1:0]  buf_rdata;

  assign in_acc     = (state == LOAD) && bus.in_valid;
  assign grant_ok   = (state == RUN) && bus.task_grant && (gcnt != FULL);
  assign grant_done = (gcnt == FULL) || (grant_ok && (gcnt == LAST_IDX));
  assign out_acc    = (state == DRAIN) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (in_acc && (bcnt == LAST_IDX)) state_nxt = REQ;
      REQ:     state_nxt = RUN;
      RUN:     if (grant_done && (end_seen || bus.task_end)) state_nxt = DRAIN;
      DRAIN:   if (out_acc && (rcnt == LAST_IDX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_last  = (state == DRAIN) && (rcnt == LAST_IDX);
  assign bus.out_data  = (state == DRAIN) ? buf_rdata : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_ena   <= 3'b000;
      bus.wr_addr  <= '0;
      bus.wr_x     <= '0;
      bus.wr_y     <= '0;
      bus.wr_m     <= '0;
      bus.wr_m1    <= '0;
      bus.task_req <= 1'b0;
      bcnt         <= '0;
      gcnt         <= '0;
      rcnt         <= '0;
      end_seen     <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      bus.wr_ena   <= in_acc ? 3'b111 : 3'b000;
      // REQ is the cycle of the final RAM write, so the start pulse lands right after it.
      bus.task_req <= (state == REQ);
      if (in_acc) begin
        bus.wr_addr <= bcnt[ADDR_W-1:0];
        bus.wr_x    <= bus.in_x;
        bus.wr_y    <= bus.in_y;
        bus.wr_m    <= bus.in_m;
        if (bcnt == '0) bus.wr_m1 <= bus.in_m1;
        if (bus.in_last != (bcnt == LAST_IDX)) proto_err <= 1'b1;
        bcnt <= bcnt + CW'(1);
      end
      if (grant_ok) gcnt <= gcnt + CW'(1);
      if ((state == RUN) && bus.task_grant && (gcnt == FULL)) proto_err <= 1'b1;
      if ((state == RUN) && bus.task_end) end_seen <= 1'b1;
      if (out_acc) rcnt <= rcnt + CW'(1);
      if ((state == DRAIN) && (state_nxt == IDLE)) begin
        bcnt     <= '0;
        gcnt     <= '0;
        rcnt     <= '0;
        end_seen <= 1'b0;
      end
    end
  end

  mmp_feeder_res_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_res_buf (
    .clk   (clk),
    .we    (grant_ok),
    .waddr (gcnt[ADDR_W-1:0]),
    .wdata (bus.task_res),
    .raddr (rcnt[ADDR_W-1:0]),
    .rdata (buf_rdata)
  );

`ifdef MMP_FEEDER_PERF_EN
  logic [15:0] run_cnt;

  // run_cnt reads d in the cycle d clocks after task_req, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt     <= 16'd0;
      perf_cycles <= 16'd0;
    end else begin
      if (bus.task_req)             run_cnt <= 16'd1;
      else if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
      if ((state == RUN) && bus.task_end && !end_seen) perf_cycles <= run_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_mmp_iddmm_feeder.sv
// Directed bench for mmp_iddmm_feeder with a behavioural core that echoes the x RAM back as results.
module tb_mmp_iddmm_feeder;
  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, proto_err;
`ifdef MMP_FEEDER_PERF_EN
  logic [15:0] perf_cycles;
`endif

  mmp_iddmm_feeder_if #(.K(K), .ADDR_W(AW)) bus ();

  mmp_iddmm_feeder #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .busy      (busy),
    .proto_err (proto_err)
`ifdef MMP_FEEDER_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [K-1:0] jx [N];
  logic [K-1:0] jy [N];
  logic [K-1:0] jm [N];
  logic [K-1:0] jm1;
  logic [K-1:0] cx [N];
  logic [K-1:0] got_d [N];
  logic         got_l [N];
  int nout, stall_err, first_ov, last_gcyc;

  logic [AW-1:0] wa [$];
  logic [2:0]    we [$];
  logic [4*K-1:0] wd [$];
  int            wcyc [$];
  int treq_n = 0;
  int treq_cyc = 0;

  always @(negedge clk) begin
    if (bus.wr_ena != 3'b000) begin
      wa.push_back(bus.wr_addr);
      we.push_back(bus.wr_ena);
      wd.push_back({bus.wr_x, bus.wr_y, bus.wr_m, bus.wr_m1});
      wcyc.push_back(cyc);
      if (bus.wr_ena[0]) cx[bus.wr_addr] = bus.wr_x;
    end
    if (bus.task_req) begin
      treq_n++;
      treq_cyc = cyc;
    end
  end

  task automatic set_job(input int seed);
    for (int i = 0; i < N; i++) begin
      jx[i] = {32'(seed), 32'(i), 32'hA5A5_0000 | 32'(i), 32'(seed * 7 + i)};
      jy[i] = ~jx[i];
      jm[i] = jx[i] ^ {4{32'h1234_5678}};
    end
    jm1 = {4{32'(seed) * 32'h0000_9E37}};
  endtask

  task automatic drive_in(input bit gap, input int bad_beat);
    int b = 0;
    int t = 0;
    bit ph = 1'b0;
    bit acc;
    while (b < N && t < 2000) begin
      ph = ~ph;
      bus.in_valid = !(gap && !ph);
      bus.in_x     = jx[b];
      bus.in_y     = jy[b];
      bus.in_m     = jm[b];
      bus.in_m1    = (b == 0) ? jm1 : ~jm1;
      bus.in_last  = (b == N - 1) || (b == bad_beat);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) b++;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (b < N) begin
      vectors++; miscompares++;
      $display("FAIL load_timeout: beats accepted %0d, required %0d", b, N);
    end
  endtask

  task automatic core_model(input int lat, input int ngr, input int end_after, input int abort_at);
    int t = 0;
    while (!bus.task_req && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.task_req) begin
      vectors++; miscompares++;
      $display("FAIL task_req_timeout: task_req 0, required 1");
      return;
    end
    @(posedge clk); #1;
    for (int i = 1; i < lat; i++) begin @(posedge clk); #1; end
    for (int g = 0; g < ngr; g++) begin
      bus.task_grant = 1'b1;
      bus.task_res   = (g < N) ? cx[g] : ~cx[0];
      bus.task_end   = (g == ngr - 1) && (end_after == 0);
      if (g == abort_at) begin
        #2 rst_n = 1'b0;
        bus.task_grant = 1'b0;
        bus.task_end   = 1'b0;
        return;
      end
      if (g == N - 1) last_gcyc = cyc;
      @(posedge clk); #1;
    end
    bus.task_grant = 1'b0;
    bus.task_end   = 1'b0;
    if (end_after > 0) begin
      for (int i = 1; i < end_after; i++) begin @(posedge clk); #1; end
      bus.task_end = 1'b1;
      @(posedge clk); #1;
      bus.task_end = 1'b0;
    end
  endtask

  task automatic sink(input bit rnd);
    bit held = 1'b0;
    logic [K-1:0] hd = '0;
    int t = 0;
    nout = 0; stall_err = 0; first_ov = -1;
    while (nout < N && t < 8000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (held && bus.out_data !== hd) stall_err++;
      held = bus.out_valid && !bus.out_ready;
      hd   = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got_d[nout] = bus.out_data;
        got_l[nout] = bus.out_last;
        nout++;
      end
      @(posedge clk); #1;
      t++;
    end
    bus.out_ready = 1'b0;
    if (nout < N) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: words received %0d, required %0d", nout, N);
    end
  endtask

  task automatic run_job(input bit gap, input bit rnd, input int bad_beat,
                         input int lat, input int ngr, input int end_after);
    fork
      drive_in(gap, bad_beat);
      core_model(lat, ngr, end_after, -1);
      sink(rnd);
    join
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_x = '0; bus.in_y = '0;
    bus.in_m = '0; bus.in_m1 = '0; bus.task_end = 1'b0; bus.task_grant = 1'b0;
    bus.task_res = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.wr_ena, bus.task_req, bus.out_valid, bus.out_last, busy, proto_err} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0", {bus.in_ready, bus.wr_ena, bus.task_req,
               bus.out_valid, bus.out_last, busy, proto_err});
    end
`ifdef MMP_FEEDER_PERF_EN
    vectors++;
    if (perf_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_perf: got %0d required 0", perf_cycles); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL load_entry: in_ready %b required 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int wb, tq, nw;
    set_job(1);
    wb = wa.size(); tq = treq_n;
    run_job(1'b0, 1'b0, -1, 6, N, 2);
    nw = wa.size() - wb;
    vectors++;
    if (nw != N) begin miscompares++; $display("FAIL basic_wr_count: got %0d required %0d", nw, N); end
    for (int i = 0; i < N && i < nw; i++) begin
      vectors++;
      if ({we[wb+i], wa[wb+i]} !== {3'b111, AW'(i)}) begin
        miscompares++; $display("FAIL basic_wr_addr[%0d]: got ena %b addr %0d required 111 %0d", i, we[wb+i], wa[wb+i], i);
      end
      vectors++;
      if (wd[wb+i] !== {jx[i], jy[i], jm[i], jm1}) begin
        miscompares++; $display("FAIL basic_wr_data[%0d]: got %h required %h", i, wd[wb+i], {jx[i], jy[i], jm[i], jm1});
      end
    end
    vectors++;
    if (treq_n - tq != 1) begin miscompares++; $display("FAIL basic_task_req_count: got %0d required 1", treq_n - tq); end
    vectors++;
    if (nw > 0 && treq_cyc != wcyc[wb+nw-1] + 1) begin
      miscompares++; $display("FAIL basic_task_req_time: got cycle %0d required %0d", treq_cyc, wcyc[wb+nw-1] + 1);
    end
    for (int i = 0; i < nout; i++) begin
      vectors++;
      if ({got_d[i], got_l[i]} !== {jx[i], 1'(i == N - 1)}) begin
        miscompares++; $display("FAIL basic_out[%0d]: got %h last %b required %h last %b", i, got_d[i], got_l[i], jx[i], i == N - 1);
      end
    end
    vectors++;
    if ({busy, proto_err} !== 2'b00) begin miscompares++; $display("FAIL basic_idle: busy,proto_err %b required 00", {busy, proto_err}); end
  endtask

  task automatic test_stall();
    int wb, nw;
    set_job(2);
    wb = wa.size();
    run_job(1'b1, 1'b1, -1, 4, N, 1);
    nw = wa.size() - wb;
    vectors++;
    if (nw != N) begin miscompares++; $display("FAIL stall_wr_count: got %0d required %0d", nw, N); end
    for (int i = 0; i < N && i < nw; i++) begin
      vectors++;
      if ({wa[wb+i], wd[wb+i]} !== {AW'(i), jx[i], jy[i], jm[i], jm1}) begin
        miscompares++; $display("FAIL stall_wr[%0d]: got addr %0d data %h", i, wa[wb+i], wd[wb+i]);
      end
    end
    for (int i = 0; i < nout; i++) begin
      vectors++;
      if ({got_d[i], got_l[i]} !== {jx[i], 1'(i == N - 1)}) begin
        miscompares++; $display("FAIL stall_out[%0d]: got %h last %b required %h", i, got_d[i], got_l[i], jx[i]);
      end
    end
    vectors++;
    if (stall_err != 0) begin miscompares++; $display("FAIL stall_hold: %0d data changes under stall, required 0", stall_err); end
  endtask

  task automatic test_end_timing();
    set_job(3);
    run_job(1'b0, 1'b0, -1, 3, N, 0);
    vectors++;
    if (first_ov - last_gcyc != 1) begin miscompares++; $display("FAIL end_coincident: drain after %0d cycles required 1", first_ov - last_gcyc); end
    vectors++;
    if (got_d[N-1] !== jx[N-1]) begin miscompares++; $display("FAIL end_coincident_data: got %h required %h", got_d[N-1], jx[N-1]); end
    set_job(4);
    run_job(1'b0, 1'b0, -1, 3, N, 10);
    vectors++;
    if (first_ov - last_gcyc != 11) begin miscompares++; $display("FAIL end_late: drain after %0d cycles required 11", first_ov - last_gcyc); end
    vectors++;
    if (got_d[0] !== jx[0]) begin miscompares++; $display("FAIL end_late_data: got %h required %h", got_d[0], jx[0]); end
  endtask

  task automatic test_proto_err();
    set_job(5);
    run_job(1'b0, 1'b0, 5, 3, N, 1);
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("FAIL proto_last: proto_err %b required 1", proto_err); end
    vectors++;
    if (got_d[6] !== jx[6]) begin miscompares++; $display("FAIL proto_last_data: got %h required %h", got_d[6], jx[6]); end
    do_reset();
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("FAIL proto_reset: proto_err %b required 0", proto_err); end
    set_job(6);
    run_job(1'b0, 1'b0, -1, 3, N + 1, 3);
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("FAIL proto_grant: proto_err %b required 1", proto_err); end
    for (int i = 0; i < nout; i++) begin
      vectors++;
      if (got_d[i] !== jx[i]) begin miscompares++; $display("FAIL proto_grant_out[%0d]: got %h required %h", i, got_d[i], jx[i]); end
    end
  endtask

  task automatic test_reset_mid_job();
    set_job(7);
    fork
      drive_in(1'b0, -1);
      core_model(5, N, 2, 11);
    join
    #1;
    vectors++;
    if ({bus.in_ready, bus.wr_ena, bus.task_req, bus.out_valid, bus.out_last, busy, proto_err} !== 9'b0 ||
        bus.out_data !== '0) begin
      miscompares++; $display("FAIL mid_reset: ctrl %b data %h required 0", {bus.in_ready, bus.wr_ena,
               bus.task_req, bus.out_valid, bus.out_last, busy, proto_err}, bus.out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_job(8);
    run_job(1'b0, 1'b1, -1, 7, N, 4);
    for (int i = 0; i < nout; i++) begin
      vectors++;
      if ({got_d[i], got_l[i]} !== {jx[i], 1'(i == N - 1)}) begin
        miscompares++; $display("FAIL mid_reset_job[%0d]: got %h last %b required %h", i, got_d[i], got_l[i], jx[i]);
      end
    end
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("FAIL mid_reset_proto: proto_err %b required 0", proto_err); end
  endtask

`ifdef MMP_FEEDER_PERF_EN
  task automatic test_perf();
    set_job(9);
    run_job(1'b0, 1'b0, -1, 10, N, 2209 - 10 - (N - 1));
    vectors++;
    if (perf_cycles !== 16'd2209) begin miscompares++; $display("FAIL perf_cycles: got %0d required 2209", perf_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_end_timing();
    test_proto_err();
    test_reset_mid_job();
`ifdef MMP_FEEDER_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
